// File: rtl/sipo_word_assembler_pkg.sv
// Shared types and helpers for the serial-to-parallel word assembler.
package sipo_word_assembler_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // One-entry output holder: either waiting for a word or presenting one.
  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_e;

  // Width of the bit counter: clog2(width), never less than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in shift register collecting qualified bits in arrival order.
module sipo_shift_reg
  import sipo_word_assembler_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter bit FIRST_BIT_MSB = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  // Shift one bit in per enabled cycle; flush on reset or clear.
  // NOTE: flops update with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      q <= '0;
    end else if (en) begin
      if (FIRST_BIT_MSB) q <= {q[WIDTH-2:0], din};
      else               q <= {din, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/sipo_word_assembler.sv
// Assembles WIDTH serial bits into a word and offers it through a
// one-entry holding register with a valid/ready handshake. A word that
// completes while the holder is still occupied is dropped and flagged.
module sipo_word_assembler
  import sipo_word_assembler_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter bit FIRST_BIT_MSB = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_in,
  input  logic             shift,
  input  logic             clear,
  output logic [WIDTH-1:0] par_data,
  output logic             par_valid,
  input  logic             par_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    bit_cnt_q;
  logic [CW-1:0]    bit_cnt_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] word_d;
  logic             complete;
  logic             transfer;
  logic             load_word;
  logic             set_overrun;
  hold_state_e      hold_q;
  hold_state_e      hold_d;

  sipo_shift_reg #(
    .WIDTH        (WIDTH),
    .FIRST_BIT_MSB(FIRST_BIT_MSB)
  ) u_shift_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clear),
    .en   (shift),
    .din  (ser_in),
    .q    (shreg_q)
  );

  // The completed word must include the bit arriving this cycle, so it is
  // formed from the pre-edge register contents plus ser_in.
  assign word_d = FIRST_BIT_MSB ? {shreg_q[WIDTH-2:0], ser_in}
                                : {ser_in, shreg_q[WIDTH-1:1]};

  assign complete = shift && (bit_cnt_q == LAST);
  assign transfer = (hold_q == HOLD_FULL) && par_ready;
  assign par_valid = (hold_q == HOLD_FULL);

  // Bit counter next value: advance on each qualified bit, wrap on completion.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (shift) bit_cnt_d = complete ? '0 : bit_cnt_q + CW'(1);
  end

  // Counter and registered busy flag (busy mirrors the new count).
  // NOTE: reset is synchronous; it only takes effect on a rising clk edge.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      bit_cnt_q <= '0;
      busy      <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      busy      <= (bit_cnt_d != '0);
    end
  end

  // Holder next state: load, drain, or drop-and-flag on a completed word.
  always_comb begin
    hold_d      = hold_q;
    load_word   = 1'b0;
    set_overrun = 1'b0;
    unique case (hold_q)
      HOLD_EMPTY: begin
        if (complete) begin
          hold_d    = HOLD_FULL;
          load_word = 1'b1;
        end
      end
      HOLD_FULL: begin
        if (complete) begin
          // Same-cycle drain and refill keeps the holder full with no bubble.
          if (transfer) load_word   = 1'b1;
          else          set_overrun = 1'b1;
        end else if (transfer) begin
          hold_d = HOLD_EMPTY;
        end
      end
      default: hold_d = HOLD_EMPTY;
    endcase
  end

  // Holder state, held word and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      hold_q   <= HOLD_EMPTY;
      par_data <= '0;
      overrun  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      if (load_word)   par_data <= word_d;
      if (set_overrun) overrun  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sipo_word_assembler.sv
// Directed bench for sipo_word_assembler: one MSB-first and one LSB-first
// instance share all stimulus; a scoreboard queue per instance holds the
// words expected to appear on par_data.
module tb_sipo_word_assembler;

  logic       clk;
  logic       rst_n;
  logic       ser_in;
  logic       shift;
  logic       clear;
  logic       par_ready;
  logic [3:0] par_data_m;
  logic [3:0] par_data_l;
  logic       par_valid_m;
  logic       par_valid_l;
  logic       busy_m;
  logic       busy_l;
  logic       overrun_m;
  logic       overrun_l;

  int unsigned n_vec;
  int unsigned n_err;
  logic [3:0]  exp_m[$];
  logic [3:0]  exp_l[$];

  sipo_word_assembler #(.WIDTH(4), .FIRST_BIT_MSB(1'b1)) dut_m (
    .clk      (clk),
    .rst_n    (rst_n),
    .ser_in   (ser_in),
    .shift    (shift),
    .clear    (clear),
    .par_data (par_data_m),
    .par_valid(par_valid_m),
    .par_ready(par_ready),
    .busy     (busy_m),
    .overrun  (overrun_m)
  );

  sipo_word_assembler #(.WIDTH(4), .FIRST_BIT_MSB(1'b0)) dut_l (
    .clk      (clk),
    .rst_n    (rst_n),
    .ser_in   (ser_in),
    .shift    (shift),
    .clear    (clear),
    .par_data (par_data_l),
    .par_valid(par_valid_l),
    .par_ready(par_ready),
    .busy     (busy_l),
    .overrun  (overrun_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] rev4(input logic [3:0] w);
    return {w[0], w[1], w[2], w[3]};
  endfunction

  // One clock; afterwards, any newly presented word is checked against
  // the head of that instance's scoreboard.
  task automatic tick();
    logic pv_m, pv_l, rdy;
    pv_m = par_valid_m;
    pv_l = par_valid_l;
    rdy  = par_ready;
    @(posedge clk);
    #1;
    if (par_valid_m && (!pv_m || rdy)) begin
      chk("msb_word_expected", 32'(exp_m.size() != 0), 32'd1);
      if (exp_m.size() != 0) chk("msb_word", 32'(par_data_m), 32'(exp_m.pop_front()));
    end
    if (par_valid_l && (!pv_l || rdy)) begin
      chk("lsb_word_expected", 32'(exp_l.size() != 0), 32'd1);
      if (exp_l.size() != 0) chk("lsb_word", 32'(par_data_l), 32'(exp_l.pop_front()));
    end
  endtask

  // Send w first-bit-first (w[3] first), with gap idle cycles after each
  // bit; optionally raise par_ready in the cycle the last bit is sampled.
  task automatic send_word(input logic [3:0] w, input int gap, input bit rdy_last);
    for (int i = 3; i >= 0; i--) begin
      shift  = 1'b1;
      ser_in = w[i];
      if (i == 0 && rdy_last) par_ready = 1'b1;
      tick();
      shift = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  initial begin
    logic [3:0] bits;
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    shift     = 1'b0;
    ser_in    = 1'b0;
    par_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_valid",   32'(par_valid_m), 32'd0);
    chk("rst_data",    32'(par_data_m),  32'd0);
    chk("rst_busy",    32'(busy_m),      32'd0);
    chk("rst_overrun", 32'(overrun_m),   32'd0);

    // Basic word 1,0,1,1 with shift held high and ready high
    par_ready = 1'b1;
    bits = 4'b1011;
    exp_m.push_back(bits);
    exp_l.push_back(rev4(bits));
    for (int i = 3; i >= 0; i--) begin
      shift  = 1'b1;
      ser_in = bits[i];
      tick();
      chk("t1_busy", 32'(busy_m), (i != 0) ? 32'd1 : 32'd0);
    end
    chk("t1_valid_rise", 32'(par_valid_m), 32'd1);
    shift = 1'b0;
    tick();
    chk("t1_valid_one_cycle", 32'(par_valid_m), 32'd0);
    chk("t1_overrun",         32'(overrun_m),   32'd0);

    // Same bits with one-cycle gaps between qualified bits
    exp_m.push_back(4'b1011);
    exp_l.push_back(4'b1101);
    send_word(4'b1011, 1, 1'b0);
    chk("t2_lsb_drained", 32'(par_valid_l), 32'd0);

    // Overrun: A held, 5 dropped, then drain and clear
    par_ready = 1'b0;
    exp_m.push_back(4'hA);
    exp_l.push_back(rev4(4'hA));
    send_word(4'hA, 0, 1'b0);
    chk("t3_no_overrun_yet", 32'(overrun_m), 32'd0);
    send_word(4'h5, 0, 1'b0);
    chk("t3_data_held",  32'(par_data_m),  32'hA);
    chk("t3_valid_held", 32'(par_valid_m), 32'd1);
    chk("t3_overrun",    32'(overrun_m),   32'd1);
    chk("t3_lsb_data",   32'(par_data_l),  32'h5);
    chk("t3_lsb_overrun",32'(overrun_l),   32'd1);
    par_ready = 1'b1;
    tick();
    par_ready = 1'b0;
    chk("t3_drained",        32'(par_valid_m), 32'd0);
    chk("t3_overrun_sticky", 32'(overrun_m),   32'd1);
    chk("t3_data_retained",  32'(par_data_m),  32'hA);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t3_clear_overrun", 32'(overrun_m),  32'd0);
    chk("t3_clear_data",    32'(par_data_m), 32'd0);

    // Drain and refill in the same cycle: 3 then C, no bubble
    exp_m.push_back(4'h3);
    exp_l.push_back(rev4(4'h3));
    exp_m.push_back(4'hC);
    exp_l.push_back(rev4(4'hC));
    send_word(4'h3, 0, 1'b0);
    chk("t4_first_valid", 32'(par_valid_m), 32'd1);
    send_word(4'hC, 0, 1'b1);
    chk("t4_valid_no_bubble", 32'(par_valid_m), 32'd1);
    chk("t4_data_new",        32'(par_data_m),  32'hC);
    chk("t4_lsb_data_new",    32'(par_data_l),  32'h3);
    chk("t4_overrun",         32'(overrun_m),   32'd0);
    tick();
    chk("t4_drained", 32'(par_valid_m), 32'd0);

    // Partial word discarded by reset
    par_ready = 1'b1;
    shift = 1'b1; ser_in = 1'b1; tick();
    ser_in = 1'b0; tick();
    shift = 1'b0;
    chk("t5_partial_busy", 32'(busy_m), 32'd1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("t5_rst_busy", 32'(busy_m), 32'd0);
    exp_m.push_back(4'hF);
    exp_l.push_back(4'hF);
    send_word(4'hF, 0, 1'b0);
    chk("t5_rst_valid", 32'(par_valid_m), 32'd1);
    tick();

    // Partial word discarded by clear
    shift = 1'b1; ser_in = 1'b0; tick();
    ser_in = 1'b0; tick();
    shift = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
    chk("t5_clr_busy", 32'(busy_m), 32'd0);
    exp_m.push_back(4'hF);
    exp_l.push_back(4'hF);
    send_word(4'hF, 0, 1'b0);
    chk("t5_clr_valid", 32'(par_valid_m), 32'd1);
    tick();

    // Reset and clear together with shift, from a busy, full, overrun state
    par_ready = 1'b0;
    exp_m.push_back(4'h9);
    exp_l.push_back(rev4(4'h9));
    send_word(4'h9, 0, 1'b0);
    send_word(4'h6, 0, 1'b0);
    shift = 1'b1; ser_in = 1'b1; tick(); tick();
    chk("t6_pre_busy",    32'(busy_m),    32'd1);
    chk("t6_pre_overrun", 32'(overrun_m), 32'd1);
    rst_n = 1'b0; clear = 1'b1; par_ready = 1'b1;
    tick();
    chk("t6_valid",     32'(par_valid_m), 32'd0);
    chk("t6_data",      32'(par_data_m),  32'd0);
    chk("t6_busy",      32'(busy_m),      32'd0);
    chk("t6_overrun",   32'(overrun_m),   32'd0);
    chk("t6_lsb_valid", 32'(par_valid_l), 32'd0);
    chk("t6_lsb_data",  32'(par_data_l),  32'd0);
    rst_n = 1'b1; clear = 1'b0; shift = 1'b0;
    exp_m.push_back(4'hF);
    exp_l.push_back(4'hF);
    send_word(4'hF, 0, 1'b0);
    tick();

    chk("msb_scoreboard_empty", 32'(exp_m.size()), 32'd0);
    chk("lsb_scoreboard_empty", 32'(exp_l.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
